// File: rtl/enc_event_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : enc_event_fifo_if
// Description : Encoder-side and consumer-side signals of the encoder event
//               FIFO. The slave modport is the FIFO's view, and the master
//               modport is the environment's view (encoder plus consumer).
// Revision    : 1.0 - initial release
// ============================================================================
interface enc_event_fifo_if #(
  parameter int CODE_W = 3
) ();
  logic [0:CODE_W-1] e;          // encoder code, MSB-first
  logic              v;          // encoder valid
  logic [0:CODE_W-1] out_code;   // FIFO head code (0 when empty)
  logic              out_valid;  // head entry present
  logic              out_ready;  // consumer accepts head

  modport master (
    output e,
    output v,
    output out_ready,
    input  out_code,
    input  out_valid
  );

  modport slave (
    input  e,
    input  v,
    input  out_ready,
    output out_code,
    output out_valid
  );
endinterface
`default_nettype wire

// File: rtl/enc_event_fifo.sv
`default_nettype none
// ============================================================================
// Module      : enc_event_fifo
// Description : Converts the combinational 8-to-3 encoder output into clocked
//               code events. Events are buffered in a small show-ahead FIFO
//               and offered downstream over valid/ready. Optional
//               de-duplication pushes only on a new event. A sticky overflow
//               flag records dropped events.
// Revision    : 1.0 - initial release
// ============================================================================
module enc_event_fifo #(
  parameter int CODE_W = 3,
  parameter int DEPTH  = 4,   // power of two, >= 2
  parameter int AW     = 2    // log2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  enc_event_fifo_if.slave       bus,
  input  logic                  dedup,
  output logic [AW:0]           count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  input  logic                  clr_ovf
);

  localparam logic [AW:0]   C_DEPTH = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] C_PTR_1 = AW'(1);
  localparam logic [AW:0]   C_CNT_1 = (AW + 1)'(1);

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              prev_v_q, prev_v_d;
  logic [0:CODE_W-1] prev_e_q, prev_e_d;
  logic [0:CODE_W-1] mem_q [DEPTH];

  logic              push_req;
  logic              pop;
  logic              push;

  // Status and head presentation. The head is forced to 0 when the FIFO is
  // empty, so that uninitialised memory never reaches the output.
  assign full          = (count_q == C_DEPTH);
  assign empty         = (count_q == '0);
  assign count         = count_q;
  assign overflow      = overflow_q;
  assign bus.out_valid = ~empty;
  assign bus.out_code  = bus.out_valid ? mem_q[rd_ptr_q] : '0;

  // Event detection, handshake, and next-state computation for all control
  // flops. A full FIFO still accepts a push when the head leaves in the
  // same cycle.
  always_comb begin
    push_req   = dedup ? (bus.v & (~prev_v_q | (bus.e != prev_e_q))) : bus.v;
    pop        = bus.out_valid & bus.out_ready;
    push       = push_req & (~full | pop);

    prev_v_d   = bus.v;
    prev_e_d   = bus.e;
    wr_ptr_d   = push ? (wr_ptr_q + C_PTR_1) : wr_ptr_q;
    rd_ptr_d   = pop  ? (rd_ptr_q + C_PTR_1) : rd_ptr_q;

    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + C_CNT_1;
      2'b01:   count_d = count_q - C_CNT_1;
      default: count_d = count_q;
    endcase

    // A drop in the same cycle as a clear leaves the flag set.
    overflow_d = overflow_q;
    if (clr_ovf)
      overflow_d = 1'b0;
    if (push_req & full & ~pop)
      overflow_d = 1'b1;
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      prev_v_q   <= 1'b0;
      prev_e_q   <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      prev_v_q   <= prev_v_d;
      prev_e_q   <= prev_e_d;
    end
  end

  // Storage array. It is never reset, because only slots below count are
  // ever observed.
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= bus.e;
  end

endmodule
`default_nettype wire

// File: doc/enc_event_fifo.md
Name: enc_event_fifo

Overview:
- Sits directly downstream of the 8-to-3 encoder and consumes its code bus `e` and valid flag `v`.
- Turns the encoder's combinational output into a stream of clocked code events.
- Buffers events in a small FIFO and presents them to the next stage through a valid/ready handshake.
- An optional de-duplication mode pushes only on a new event, not on every cycle that `v` is high.

Parameters:
- CODE_W, 3, width of the encoder code bus.
- DEPTH, 4, FIFO entries; must be a power of two, minimum 2.
- AW, 2, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- e  input  [0:CODE_W-1]  code from the encoder; same MSB-first bit ordering as the encoder output.
- v  input  1  encoder valid; 1 = at least one request line active.
- dedup  input  1  1 = push only on new events; 0 = push every cycle v=1.
- out_code  output  [0:CODE_W-1]  FIFO head code.
- out_valid  output  1  head entry is present.
- out_ready  input  1  consumer accepts the head entry.
- count  output  AW+1  number of entries stored.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky flag: an event was dropped.
- clr_ovf  input  1  synchronous clear of overflow.

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0:
  - read/write pointers = 0, count = 0, empty = 1, full = 0, overflow = 0;
  - out_valid = 0, out_code = 0;
  - history registers prev_v = 0, prev_e = 0.
  - FIFO memory contents need no reset.
- History: on every edge out of reset, prev_v <= v and prev_e <= e.
- Push request (push_req), evaluated combinationally from current inputs:
  - dedup=0: push_req = v.
  - dedup=1: push_req = v & (~prev_v | (e != prev_e)).
  - Consequence: a held request pushes once; a change of highest-priority code pushes again.
- Pop: pop = out_valid & out_ready.
- Push acceptance: push = push_req & (~full | pop).
  - A push into a full FIFO is accepted when a pop happens in the same cycle.
- On an accepted push: mem[wr_ptr] <= e, and wr_ptr increments modulo DEPTH (natural wrap).
- On a pop: rd_ptr increments modulo DEPTH.
- count update:
  - +1 for push only;
  - -1 for pop only;
  - unchanged for push+pop, or for neither.
- Outputs:
  - full and empty are derived from count.
  - out_valid = ~empty.
  - out_code = mem[rd_ptr] when out_valid = 1, else 0 (show-ahead head, never X).
- Latency: an event sampled at edge N into an empty FIFO gives out_valid = 1 and out_code = code after edge N. That is one cycle of latency.
- Pop while empty cannot occur (out_valid = 0); out_ready is ignored when empty.
- Push+pop with count = 1 leaves count = 1, with the new code at the head after the edge.
- Overflow:
  - Set when push_req & full & ~pop; the event is dropped and memory and pointers are unchanged.
  - Cleared by clr_ovf = 1 at the edge.
  - If a set condition and clr_ovf occur in the same cycle, set wins.
- out_valid and out_code hold stable while out_ready = 0; the consumer may stall indefinitely.
- Mid-operation reset discards all entries immediately. The first push after release is judged against prev_v = 0.
- Width rule: count is AW+1 bits so it can represent DEPTH.

Test Plan:
- Reset value check: assert rst_n=0 mid-stream with count=3 -> immediately empty=1, out_valid=0, out_code=0, count=0, overflow=0.
- dedup=1, out_ready=0, hold v=1 with e=3'b101 for 5 cycles, then e=3'b110 for 2 cycles -> count=2. Then out_ready=1 -> out_code=101 then 110, then empty=1.
- dedup=0, out_ready=0, v=1 for 6 cycles with e=3'b011 (DEPTH=4):
  - -> full=1 after the 4th edge, overflow=1 after the 5th;
  - -> count stays 4;
  - -> clr_ovf=1 alone clears the flag;
  - -> clr_ovf=1 together with another drop keeps overflow=1.
- Full FIFO, out_ready=1 and push_req=1 on the same cycle with e=3'b111 -> count stays 4, overflow stays 0, 3'b111 read out last.
- Wrap-around, dedup=0: push 10 distinct codes (0..7, then 1, 2) with out_ready=1 continuously -> every code is read in order, one cycle after entry, with no loss and count never exceeding 1.
- Drive e/v from the encoder instance with `in` sweeping 0..127 (one value per 5 ns), dedup=1 -> out_code sequence matches the code changes observed on e, no entries while v=0.
